// File: rtl/tlb_maint_pkg.sv
// Shared types for the TLB maintenance sequencer.
//   tlb_op_t     : maintenance operation code (SRCH, RD, WR, FILL, INV)
//   tlb_entry_t  : one TLB entry as packed from TLBIDX/TLBEHI/TLBELO0/1/ASID
//   tlb_result_t : TLB search port result
//   state_e      : sequencer FSM state
package tlb_maint_pkg;

  localparam int unsigned TLBNUM   = 16;
  localparam int unsigned TLBIDLEN = $clog2(TLBNUM);

  // Highest INVTLB op code the TLB understands; anything above raises INE.
  localparam logic [4:0] InvOpMax = 5'd6;

  typedef enum logic [2:0] {
    OpSrch = 3'd0,
    OpRd   = 3'd1,
    OpWr   = 3'd2,
    OpFill = 3'd3,
    OpInv  = 3'd4
  } tlb_op_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                found;
    logic [TLBIDLEN-1:0] index;
    logic [19:0]         ppn;
    logic [5:0]          ps;
    logic [1:0]          plv;
    logic [1:0]          mat;
    logic                d;
    logic                v;
  } tlb_result_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  // Entry written by TLBWR/TLBFILL: the valid bit comes from NE, forced on in the TLBR handler.
  function automatic tlb_entry_t write_entry(tlb_entry_t ent, logic tlbr, logic ne);
    tlb_entry_t r;
    r   = ent;
    r.e = tlbr | ~ne;
    return r;
  endfunction

endpackage

// File: rtl/tlbfill_index_gen.sv
// Free-running TLBFILL index counter: counts 0..TLBNUM-1 and wraps, one step per cycle.
//   clk_i    : clock
//   resetn_i : asynchronous active-low reset (counter to 0)
//   idx_o    : current fill index
module tlbfill_index_gen #(
  parameter int unsigned TLBNUM   = 16,
  parameter int unsigned TLBIDLEN = $clog2(TLBNUM)
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  output logic [TLBIDLEN-1:0] idx_o
);

  localparam logic [TLBIDLEN-1:0] IdxMax = TLBIDLEN'(TLBNUM - 1);

  logic [TLBIDLEN-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/tlb_maint.sv
// TLB maintenance sequencer (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Accepts one op via req_valid/req_ready, runs IDLE -> EXEC -> DONE and pulses resp_valid_o.
//   req_*         : operation request and INVTLB operands
//   csr_*         : CSR operands, captured at accept
//   s2_* / s2_result_i        : TLB search port 2
//   tlb_r_index_o / tlb_r_entry_i : TLB read port
//   tlb_we_o / tlb_w_*        : TLB write port (pulse in EXEC)
//   invtlb_*                  : TLB invtlb port (pulse in EXEC)
//   resp_*                    : completion to the CSR file, held until the next DONE
module tlb_maint #(
  parameter int unsigned TLBNUM   = tlb_maint_pkg::TLBNUM,
  parameter int unsigned TLBIDLEN = $clog2(TLBNUM)
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  tlb_maint_pkg::tlb_op_t      req_op_i,
  input  logic [4:0]                  req_invop_i,
  input  logic [9:0]                  req_asid_i,
  input  logic [31:0]                 req_va_i,
  input  logic [18:0]                 csr_vppn_i,
  input  logic [9:0]                  csr_asid_i,
  input  logic [TLBIDLEN-1:0]         csr_index_i,
  input  logic                        csr_ne_i,
  input  logic                        csr_tlbr_i,
  input  tlb_maint_pkg::tlb_entry_t   csr_entry_i,
  output logic [18:0]                 s2_vppn_o,
  output logic                        s2_va_bit12_o,
  output logic [9:0]                  s2_asid_o,
  input  tlb_maint_pkg::tlb_result_t  s2_result_i,
  output logic [TLBIDLEN-1:0]         tlb_r_index_o,
  input  tlb_maint_pkg::tlb_entry_t   tlb_r_entry_i,
  output logic                        tlb_we_o,
  output logic [TLBIDLEN-1:0]         tlb_w_index_o,
  output tlb_maint_pkg::tlb_entry_t   tlb_w_entry_o,
  output logic                        invtlb_valid_o,
  output logic [4:0]                  invtlb_op_o,
  output logic [9:0]                  invtlb_asid_o,
  output logic [31:0]                 invtlb_va_o,
  output logic                        resp_valid_o,
  output tlb_maint_pkg::tlb_op_t      resp_op_o,
  output logic                        resp_found_o,
  output logic [TLBIDLEN-1:0]         resp_index_o,
  output tlb_maint_pkg::tlb_entry_t   resp_entry_o,
  output logic                        resp_inv_err_o
);

  import tlb_maint_pkg::*;

  state_e state_q, state_d;
  logic   accept;

  logic [TLBIDLEN-1:0] fill_idx;

  // Operand bank
  tlb_op_t             op_q;
  logic [4:0]          invop_q;
  logic [9:0]          inv_asid_q;
  logic [31:0]         inv_va_q;
  logic [18:0]         vppn_q;
  logic [9:0]          asid_q;
  logic [TLBIDLEN-1:0] index_q;
  logic [TLBIDLEN-1:0] fill_idx_q;
  tlb_entry_t          w_entry_q;

  // Response bank
  tlb_op_t             resp_op_q, resp_op_d;
  logic                resp_found_q, resp_found_d;
  logic [TLBIDLEN-1:0] resp_index_q, resp_index_d;
  tlb_entry_t          resp_entry_q, resp_entry_d;
  logic                resp_err_q, resp_err_d;

  logic inv_ok;

  tlbfill_index_gen #(
    .TLBNUM   (TLBNUM),
    .TLBIDLEN (TLBIDLEN)
  ) u_fill_idx (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .idx_o    (fill_idx)
  );

  assign accept = req_valid_i && req_ready_o;
  assign inv_ok = (invop_q <= InvOpMax);

  // FSM: state register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture at accept; later input changes are ignored.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      op_q       <= OpSrch;
      invop_q    <= '0;
      inv_asid_q <= '0;
      inv_va_q   <= '0;
      vppn_q     <= '0;
      asid_q     <= '0;
      index_q    <= '0;
      fill_idx_q <= '0;
      w_entry_q  <= '0;
    end else if (accept) begin
      op_q       <= req_op_i;
      invop_q    <= req_invop_i;
      inv_asid_q <= req_asid_i;
      inv_va_q   <= req_va_i;
      vppn_q     <= csr_vppn_i;
      asid_q     <= csr_asid_i;
      index_q    <= csr_index_i;
      fill_idx_q <= fill_idx;
      w_entry_q  <= write_entry(csr_entry_i, csr_tlbr_i, csr_ne_i);
    end
  end

  // Response values sampled from the combinational TLB ports at the end of EXEC.
  always_comb begin
    resp_op_d    = op_q;
    resp_found_d = (op_q == OpSrch) && s2_result_i.found;
    resp_index_d = (op_q == OpSrch) ? TLBIDLEN'(s2_result_i.index) : '0;
    resp_entry_d = (op_q == OpRd) ? tlb_r_entry_i : '0;
    resp_err_d   = (op_q == OpInv) && !inv_ok;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      resp_op_q    <= OpSrch;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_entry_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (state_q == StExec) begin
      resp_op_q    <= resp_op_d;
      resp_found_q <= resp_found_d;
      resp_index_q <= resp_index_d;
      resp_entry_q <= resp_entry_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // FSM: outputs
  always_comb begin
    req_ready_o    = (state_q == StIdle);
    resp_valid_o   = (state_q == StDone);
    tlb_we_o       = 1'b0;
    tlb_w_index_o  = '0;
    tlb_w_entry_o  = '0;
    invtlb_valid_o = 1'b0;
    invtlb_op_o    = '0;
    invtlb_asid_o  = '0;
    invtlb_va_o    = '0;
    if (state_q == StExec) begin
      case (op_q)
        OpWr: begin
          tlb_we_o      = 1'b1;
          tlb_w_index_o = index_q;
          tlb_w_entry_o = w_entry_q;
        end
        OpFill: begin
          tlb_we_o      = 1'b1;
          tlb_w_index_o = fill_idx_q;
          tlb_w_entry_o = w_entry_q;
        end
        OpInv: begin
          if (inv_ok) begin
            invtlb_valid_o = 1'b1;
            invtlb_op_o    = invop_q;
            invtlb_asid_o  = inv_asid_q;
            invtlb_va_o    = inv_va_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Search and read addresses hold their captured values outside EXEC too.
  assign s2_vppn_o     = vppn_q;
  assign s2_asid_o     = asid_q;
  assign s2_va_bit12_o = 1'b0;
  assign tlb_r_index_o = index_q;

  assign resp_op_o      = resp_op_q;
  assign resp_found_o   = resp_found_q;
  assign resp_index_o   = resp_index_q;
  assign resp_entry_o   = resp_entry_q;
  assign resp_inv_err_o = resp_err_q;

  // Translation fields of the search result are consumed by the CSR file via RD, not here.
  logic unused_s2;
  assign unused_s2 = ^{s2_result_i.ppn, s2_result_i.ps, s2_result_i.plv, s2_result_i.mat,
                       s2_result_i.d, s2_result_i.v};

endmodule

// File: tb/tb_tlb_maint.sv
// Self-checking bench for tlb_maint with a behavioural TLB and reference entry array.
module tb_tlb_maint;
  import tlb_maint_pkg::*;

  localparam int N = 16;

  logic        clk, resetn, clr;
  logic        req_valid, req_ready;
  tlb_op_t     req_op, resp_op;
  logic [4:0]  req_invop, invtlb_op;
  logic [9:0]  req_asid, csr_asid, s2_asid, invtlb_asid;
  logic [31:0] req_va, invtlb_va;
  logic [18:0] csr_vppn, s2_vppn;
  logic [3:0]  csr_index, tlb_r_index, tlb_w_index, resp_index;
  logic        csr_ne, csr_tlbr, s2_va_bit12, tlb_we, invtlb_valid;
  logic        resp_valid, resp_found, resp_inv_err;
  tlb_entry_t  csr_entry, tlb_r_entry, tlb_w_entry, resp_entry;
  tlb_result_t s2_result;

  int checks, errors;

  tlb_maint #(.TLBNUM(N)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_invop_i(req_invop), .req_asid_i(req_asid), .req_va_i(req_va),
    .csr_vppn_i(csr_vppn), .csr_asid_i(csr_asid), .csr_index_i(csr_index),
    .csr_ne_i(csr_ne), .csr_tlbr_i(csr_tlbr), .csr_entry_i(csr_entry),
    .s2_vppn_o(s2_vppn), .s2_va_bit12_o(s2_va_bit12), .s2_asid_o(s2_asid),
    .s2_result_i(s2_result),
    .tlb_r_index_o(tlb_r_index), .tlb_r_entry_i(tlb_r_entry),
    .tlb_we_o(tlb_we), .tlb_w_index_o(tlb_w_index), .tlb_w_entry_o(tlb_w_entry),
    .invtlb_valid_o(invtlb_valid), .invtlb_op_o(invtlb_op), .invtlb_asid_o(invtlb_asid),
    .invtlb_va_o(invtlb_va),
    .resp_valid_o(resp_valid), .resp_op_o(resp_op), .resp_found_o(resp_found),
    .resp_index_o(resp_index), .resp_entry_o(resp_entry), .resp_inv_err_o(resp_inv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural TLB driven by the DUT's ports.
  tlb_entry_t mem [N];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (tlb_we) begin
      mem[tlb_w_index] <= tlb_w_entry;
    end
  end
  always_comb begin
    s2_result = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mem[i].e && mem[i].vppn == s2_vppn && (mem[i].g || mem[i].asid == s2_asid)) begin
        s2_result.found = 1'b1;
        s2_result.index = 4'(i);
      end
    end
    tlb_r_entry = mem[tlb_r_index];
  end

  // Cycles elapsed since reset release; the fill index is this count modulo N.
  int unsigned cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Reference contents the TLB should hold.
  tlb_entry_t ref_mem [N];

  // Snapshots: EXEC cycle (ex_), DONE cycle (dn_), cycle after DONE (af_).
  logic [3:0]  exp_fill;
  logic        ex_we, ex_inv_v, ex_ready, ex_resp_valid, ex_b12;
  logic [3:0]  ex_widx, ex_ridx;
  tlb_entry_t  ex_wentry;
  logic [4:0]  ex_inv_op;
  logic [9:0]  ex_inv_asid, ex_s2_asid;
  logic [31:0] ex_inv_va;
  logic [18:0] ex_s2_vppn;
  logic        dn_valid, dn_found, dn_err, dn_we, dn_inv_v;
  tlb_op_t     dn_op, af_op;
  logic [3:0]  dn_index;
  tlb_entry_t  dn_entry;
  logic        af_ready, af_valid;

  function automatic tlb_entry_t rand_entry();
    logic [95:0] r;
    tlb_entry_t  e;
    r = {$urandom(), $urandom(), $urandom()};
    e = r[$bits(tlb_entry_t)-1:0];
    return e;
  endfunction

  function automatic logic [4:0] ref_search(logic [18:0] vppn, logic [9:0] asid);
    for (int i = 0; i < N; i++) begin
      if (ref_mem[i].e && ref_mem[i].vppn == vppn && (ref_mem[i].g || ref_mem[i].asid == asid))
        return {1'b1, 4'(i)};
    end
    return 5'b0;
  endfunction

  task automatic scramble();
    req_op    = tlb_op_t'(3'($urandom_range(0, 4)));
    req_invop = 5'($urandom);
    req_asid  = 10'($urandom);
    req_va    = $urandom;
    csr_vppn  = 19'($urandom);
    csr_asid  = 10'($urandom);
    csr_index = 4'($urandom);
    csr_ne    = 1'($urandom);
    csr_tlbr  = 1'($urandom);
    csr_entry = rand_entry();
  endtask

  task automatic apply_reset();
    resetn = 1'b0; clr = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0; resetn = 1'b1;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  // Issue the op currently on the request inputs and record the three following cycles.
  task automatic run_op();
    int n;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout ready=%0b want 1", req_ready);
    end
    exp_fill = 4'(cyc % N);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    ex_we = tlb_we; ex_widx = tlb_w_index; ex_wentry = tlb_w_entry; ex_ridx = tlb_r_index;
    ex_inv_v = invtlb_valid; ex_inv_op = invtlb_op; ex_inv_asid = invtlb_asid;
    ex_inv_va = invtlb_va; ex_ready = req_ready; ex_resp_valid = resp_valid;
    ex_s2_vppn = s2_vppn; ex_s2_asid = s2_asid; ex_b12 = s2_va_bit12;
    @(posedge clk); #1;
    dn_valid = resp_valid; dn_op = resp_op; dn_found = resp_found; dn_index = resp_index;
    dn_entry = resp_entry; dn_err = resp_inv_err; dn_we = tlb_we; dn_inv_v = invtlb_valid;
    @(posedge clk); #1;
    af_ready = req_ready; af_valid = resp_valid; af_op = resp_op;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clr = 1'b1; req_valid = 1'b0;
    #1;
    checks++;
    if ({req_ready, tlb_we, invtlb_valid, resp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000", {req_ready, tlb_we, invtlb_valid, resp_valid});
    end
    checks++;
    if ({resp_found, resp_inv_err, resp_index} !== 6'b0 || resp_op !== OpSrch) begin
      errors++;
      $display("FAIL reset_resp got %b op=%0d want 0 op=0",
               {resp_found, resp_inv_err, resp_index}, resp_op);
    end
    checks++;
    if (resp_entry !== '0) begin
      errors++; $display("FAIL reset_entry got %h want 0", resp_entry);
    end
    apply_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release ready=%0b valid=%0b want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_wr();
    tlb_entry_t e, exp;
    e = rand_entry();
    e.vppn = 19'h12345; e.asid = 10'd3; e.g = 1'b0; e.e = 1'b0;
    exp = e; exp.e = 1'b1;
    req_op = OpWr; csr_index = 4'd5; csr_ne = 1'b0; csr_tlbr = 1'b0; csr_entry = e;
    run_op();
    ref_mem[5] = exp;
    checks++;
    if ({ex_we, ex_widx, ex_ready, ex_resp_valid} !== {1'b1, 4'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_exec we/idx/ready/valid got %b want 1_0101_0_0",
               {ex_we, ex_widx, ex_ready, ex_resp_valid});
    end
    checks++;
    if (ex_wentry !== exp) begin
      errors++; $display("FAIL wr_entry got %h want %h", ex_wentry, exp);
    end
    checks++;
    if (dn_valid !== 1'b1 || dn_op !== OpWr || dn_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_done valid=%0b op=%0d we=%0b want 1/2/0", dn_valid, dn_op, dn_we);
    end
    checks++;
    if ({dn_found, dn_err} !== 2'b00 || dn_entry !== '0) begin
      errors++; $display("FAIL wr_resp_zero found=%0b err=%0b entry=%h want 0",
                         dn_found, dn_err, dn_entry);
    end
    checks++;
    if (af_ready !== 1'b1 || af_valid !== 1'b0 || af_op !== OpWr) begin
      errors++; $display("FAIL wr_after ready=%0b valid=%0b op=%0d want 1/0/2",
                         af_ready, af_valid, af_op);
    end
  endtask

  task automatic test_srch();
    logic [18:0] v;
    logic [9:0]  a;
    logic [4:0]  exp;
    for (int k = 0; k < 10; k++) begin
      if (k < 2) begin
        v = 19'h12345; a = (k == 0) ? 10'd3 : 10'd4;
      end else begin
        int j;
        j = $urandom_range(0, N - 1);
        v = $urandom_range(0, 1) ? ref_mem[j].vppn : 19'($urandom);
        a = $urandom_range(0, 1) ? ref_mem[j].asid : 10'($urandom);
      end
      exp = ref_search(v, a);
      req_op = OpSrch; csr_vppn = v; csr_asid = a;
      run_op();
      checks++;
      if ({ex_s2_vppn, ex_s2_asid, ex_b12} !== {v, a, 1'b0}) begin
        errors++; $display("FAIL srch_port vppn=%h asid=%h b12=%0b want %h/%h/0",
                           ex_s2_vppn, ex_s2_asid, ex_b12, v, a);
      end
      checks++;
      if ({dn_found, dn_index} !== exp || dn_op !== OpSrch || dn_valid !== 1'b1) begin
        errors++; $display("FAIL srch_%0d found/idx=%b op=%0d got, want %b op=0",
                           k, {dn_found, dn_index}, dn_op, exp);
      end
    end
  endtask

  task automatic test_e_bit();
    tlb_entry_t e;
    for (int k = 0; k < 4; k++) begin
      e = rand_entry();
      req_op = OpWr; csr_index = 4'($urandom); csr_entry = e;
      csr_ne = k[1]; csr_tlbr = k[0];
      e.e = k[0] | ~k[1];
      ref_mem[csr_index] = e;
      run_op();
      checks++;
      if (ex_we !== 1'b1 || ex_wentry !== e) begin
        errors++; $display("FAIL e_bit ne=%0b tlbr=%0b got e=%0b want e=%0b",
                           k[1], k[0], ex_wentry.e, e.e);
      end
    end
  endtask

  task automatic test_fill();
    tlb_entry_t e;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 0) repeat (7) @(posedge clk);
      else if (k == 1) repeat (8) @(posedge clk);
      else repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      e = rand_entry();
      req_op = OpFill; csr_entry = e; csr_ne = 1'($urandom); csr_tlbr = 1'($urandom);
      csr_index = 4'($urandom);
      e.e = csr_tlbr | ~csr_ne;
      run_op();
      ref_mem[exp_fill] = e;
      checks++;
      if (k == 0 && ex_widx !== 4'd7) begin
        errors++; $display("FAIL fill_cycle7 idx=%0d want 7", ex_widx);
      end
      if (k == 1) checks++;
      if (k == 1 && ex_widx !== 4'd2) begin
        errors++; $display("FAIL fill_cycle18 idx=%0d want 2", ex_widx);
      end
      checks++;
      if (ex_we !== 1'b1 || ex_widx !== exp_fill || ex_wentry !== e || dn_op !== OpFill) begin
        errors++; $display("FAIL fill_%0d we=%0b idx=%0d op=%0d want 1/%0d/3",
                           k, ex_we, ex_widx, dn_op, exp_fill);
      end
    end
  endtask

  task automatic test_rd();
    logic [3:0] i;
    for (int k = 0; k < 8; k++) begin
      i = 4'($urandom);
      req_op = OpRd; csr_index = i;
      run_op();
      checks++;
      if (ex_ridx !== i || dn_entry !== ref_mem[i] || dn_found !== 1'b0 || dn_op !== OpRd) begin
        errors++; $display("FAIL rd_%0d idx=%0d entry=%h got, want idx=%0d entry=%h",
                           k, ex_ridx, dn_entry, i, ref_mem[i]);
      end
    end
  endtask

  task automatic test_inv();
    logic [4:0]  iv;
    logic [9:0]  a;
    logic [31:0] v;
    logic        ok;
    for (int k = 0; k < 10; k++) begin
      iv = (k == 0) ? 5'd5 : (k == 1) ? 5'd9 : 5'($urandom);
      a = 10'($urandom); v = $urandom;
      req_op = OpInv; req_invop = iv; req_asid = a; req_va = v;
      ok = (iv <= 5'd6);
      run_op();
      checks++;
      if (ex_inv_v !== ok || ex_we !== 1'b0) begin
        errors++; $display("FAIL inv_pulse op=%0d valid=%0b we=%0b want %0b/0",
                           iv, ex_inv_v, ex_we, ok);
      end
      checks++;
      if (ok && {ex_inv_op, ex_inv_asid, ex_inv_va} !== {iv, a, v}) begin
        errors++; $display("FAIL inv_operands got %0d/%h/%h want %0d/%h/%h",
                           ex_inv_op, ex_inv_asid, ex_inv_va, iv, a, v);
      end
      checks++;
      if (dn_err !== !ok || dn_valid !== 1'b1 || dn_op !== OpInv || dn_inv_v !== 1'b0) begin
        errors++; $display("FAIL inv_resp op=%0d err=%0b valid=%0b want err=%0b valid=1",
                           iv, dn_err, dn_valid, !ok);
      end
    end
  endtask

  task automatic test_back_to_back();
    tlb_op_t    op;
    tlb_entry_t we, exp_entry;
    logic [4:0] exp_srch;
    logic       exp_err;
    logic [3:0] widx;
    int         j;
    for (int k = 0; k < 15; k++) begin
      scramble();
      op = req_op;
      if (op == OpSrch && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, N - 1);
        csr_vppn = ref_mem[j].vppn; csr_asid = ref_mem[j].asid;
      end
      exp_srch  = (op == OpSrch) ? ref_search(csr_vppn, csr_asid) : 5'b0;
      exp_entry = (op == OpRd) ? ref_mem[csr_index] : '0;
      exp_err   = (op == OpInv) && (req_invop > 5'd6);
      we = csr_entry; we.e = csr_tlbr | ~csr_ne;
      widx = csr_index;
      run_op();
      if (op == OpFill) widx = exp_fill;
      if (op == OpWr || op == OpFill) ref_mem[widx] = we;
      checks++;
      if (ex_we !== (op == OpWr || op == OpFill) ||
          ((op == OpWr || op == OpFill) && (ex_widx !== widx || ex_wentry !== we))) begin
        errors++; $display("FAIL b2b_write_%0d op=%0d we=%0b idx=%0d want idx=%0d",
                           k, op, ex_we, ex_widx, widx);
      end
      checks++;
      if (dn_valid !== 1'b1 || dn_op !== op || {dn_found, dn_index} !== exp_srch ||
          dn_entry !== exp_entry || dn_err !== exp_err || af_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_resp_%0d op=%0d/%0d srch=%b/%b err=%0b/%0b got/want",
                           k, dn_op, op, {dn_found, dn_index}, exp_srch, dn_err, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] i;
    tlb_entry_t old;
    logic       bad;
    i = 4'($urandom);
    old = ref_mem[i];
    req_op = OpWr; csr_index = i; csr_entry = rand_entry(); csr_ne = 1'b0; csr_tlbr = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (tlb_we !== 1'b1) begin
      errors++; $display("FAIL rstmid_exec we=%0b want 1", tlb_we);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({tlb_we, resp_valid, req_ready} !== 3'b001) begin
      errors++; $display("FAIL rstmid_drop we/valid/ready=%b want 001",
                         {tlb_we, resp_valid, req_ready});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (tlb_we || resp_valid || !req_ready) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rstmid_after stray activity=1 want 0");
    end
    req_op = OpRd; csr_index = i;
    run_op();
    checks++;
    if (dn_entry !== old) begin
      errors++; $display("FAIL rstmid_nowrite entry=%h want %h", dn_entry, old);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    scramble();
    test_reset();
    test_wr();
    test_srch();
    test_e_bit();
    test_fill();
    test_rd();
    test_inv();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
